// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and its byte FIFO.
// Holds the UART clock/baud constants, the drain FSM state encoding and the
// arbiter grant encoding.
package uart_tx_sched_pkg;

  localparam int unsigned CLK_HZ   = 32'd50_000_000;
  localparam int unsigned BAUD     = 32'd115_200;
  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

  // Drain FSM states: idle, order pulse cycle, waiting for transmitter idle.
  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ORDER = 2'd1,
    D_WAIT  = 2'd2
  } drain_state_e;

  // Port that won the most recent acceptance.
  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } grant_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the requesters, the scheduler and the UART
// transmitter.
//   core_valid/core_data/core_size/core_ready : core word request (1-4 bytes)
//   dbg_valid/dbg_data/dbg_ready              : debug byte request
//   tx_order/tx_data/tx_sendable              : transmitter order handshake
// slave  : the scheduler side (consumes requests, drives the transmitter).
// master : the environment side (requesters plus transmitter).
interface uart_tx_sched_if;
  logic        core_valid;
  logic [31:0] core_data;
  logic [1:0]  core_size;
  logic        core_ready;
  logic        dbg_valid;
  logic [7:0]  dbg_data;
  logic        dbg_ready;
  logic        tx_order;
  logic [7:0]  tx_data;
  logic        tx_sendable;

  modport slave (
    input  core_valid, core_data, core_size,
    input  dbg_valid, dbg_data,
    input  tx_sendable,
    output core_ready, dbg_ready,
    output tx_order, tx_data
  );

  modport master (
    output core_valid, core_data, core_size,
    output dbg_valid, dbg_data,
    output tx_sendable,
    input  core_ready, dbg_ready,
    input  tx_order, tx_data
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered occupancy count and a first-word-fall-through
// head. Also usable on the receive side.
//   clk, rstn      : clock, synchronous active-low reset
//   push/push_data : write one byte (ignored while full)
//   pop            : drop the head byte (ignored while empty)
//   head           : oldest byte, valid while empty=0
//   full/empty     : decoded from the registered count
//   count          : bytes currently stored (0..DEPTH)
module uart_byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              pop,
  output logic [7:0]        head,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Full is taken from the registered count, so a pop in the same cycle
  // never frees room for a push.
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(ADDR_W+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
    end
  end

  // Occupancy: +1, -1, or unchanged when push and pop coincide.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Byte scheduler sharing one UART transmitter between the core output port
// (1-4 byte words) and a debug byte port. Accepted bytes are queued in a
// byte FIFO and drained one frame at a time through the transmitter's
// order/data/sendable handshake.
//   clk, rstn  : clock, synchronous active-low reset
//   bus        : request and transmitter handshakes (slave modport)
//   fifo_count : bytes currently queued
//   busy       : serializer active, bytes queued, or a frame being ordered
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_sched_if.slave   bus,
  output logic [ADDR_W:0]  fifo_count,
  output logic             busy
);

  grant_e       last_grant_r;
  logic         ser_active_r;
  logic [31:0]  shift_r;
  logic [1:0]   rem_r;
  drain_state_e state_r;
  logic         tx_order_r;
  logic [7:0]   tx_data_r;

  logic         full_s;
  logic         empty_s;
  logic [7:0]   head_s;
  logic         ser_idle_s;
  logic         core_acc_s;
  logic         dbg_acc_s;
  logic         push_s;
  logic [7:0]   push_data_s;
  logic         pop_s;

  // Readies depend only on registered state and the other port's valid.
  // When both request, the port that did not win last time gets the slot.
  // Holding both readies low while the serializer runs keeps a core word
  // contiguous in the FIFO.
  assign ser_idle_s     = ~ser_active_r;
  assign bus.core_ready = ser_idle_s & ~full_s & (~bus.dbg_valid  | (last_grant_r == DBG));
  assign bus.dbg_ready  = ser_idle_s & ~full_s & (~bus.core_valid | (last_grant_r == CORE));
  assign core_acc_s     = bus.core_valid & bus.core_ready;
  assign dbg_acc_s      = bus.dbg_valid & bus.dbg_ready;

  // Pop the head the same cycle the order is registered.
  assign pop_s = (state_r == D_IDLE) & ~empty_s & bus.tx_sendable;

  assign bus.tx_order = tx_order_r;
  assign bus.tx_data  = tx_data_r;
  assign busy = ser_active_r | (fifo_count != {(ADDR_W+1){1'b0}}) | (state_r != D_IDLE);

  // FIFO write source: a debug accept and an active serializer are mutually
  // exclusive because debug is only accepted while the serializer is idle.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = 8'd0;
    if (dbg_acc_s) begin
      push_s      = 1'b1;
      push_data_s = bus.dbg_data;
    end else if (ser_active_r && !full_s) begin
      push_s      = 1'b1;
      push_data_s = shift_r[7:0];
    end else begin
      push_s      = 1'b0;
      push_data_s = 8'd0;
    end
  end

  // Grant history and core word serializer; a full FIFO simply stalls it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_r <= DBG;
      ser_active_r <= 1'b0;
      shift_r      <= 32'd0;
      rem_r        <= 2'd0;
    end else begin
      if (core_acc_s) begin
        last_grant_r <= CORE;
        ser_active_r <= 1'b1;
        shift_r      <= bus.core_data;
        rem_r        <= bus.core_size;
      end else if (dbg_acc_s) begin
        last_grant_r <= DBG;
      end else if (ser_active_r && !full_s) begin
        shift_r <= {8'd0, shift_r[31:8]};
        if (rem_r == 2'd0) begin
          ser_active_r <= 1'b0;
        end else begin
          rem_r <= rem_r - 2'd1;
        end
      end
    end
  end

  // Drain FSM: one order pulse per frame, then wait for the transmitter to
  // report idle again before the next order can be considered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= D_IDLE;
      tx_order_r <= 1'b0;
      tx_data_r  <= 8'd0;
    end else begin
      case (state_r)
        D_IDLE: begin
          if (pop_s) begin
            tx_data_r  <= head_s;
            tx_order_r <= 1'b1;
            state_r    <= D_ORDER;
          end else begin
            tx_order_r <= 1'b0;
          end
        end
        D_ORDER: begin
          tx_order_r <= 1'b0;
          state_r    <= D_WAIT;
        end
        D_WAIT: begin
          tx_order_r <= 1'b0;
          if (bus.tx_sendable) begin
            state_r <= D_IDLE;
          end
        end
        default: begin
          tx_order_r <= 1'b0;
          state_r    <= D_IDLE;
        end
      endcase
    end
  end

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (fifo_count)
  );

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Byte scheduler in front of the UART transmitter. It shares one transmitter between two requesters: the core output port (1–4 byte words) and a debug/monitor byte port. Accepted bytes go into a byte FIFO. The FIFO is drained into the transmitter's order/write_data/sendable handshake, one frame at a time. It sits between the core I/O unit and the transmitter instance, on the same clk/rstn.

Parameters:
DEPTH, 16, FIFO entries in bytes; power of two, at least 2.
ADDR_W, 4, log2(DEPTH).

Ports:
clk  in  1  system clock.
rstn  in  1  synchronous active-low reset.
core_valid  in  1  core word request.
core_data  in  32  word to send; byte 0 = bits [7:0].
core_size  in  2  number of bytes minus 1 (0 = 1 byte, 3 = 4 bytes).
core_ready  out  1  core word accepted when core_valid & core_ready.
dbg_valid  in  1  debug byte request.
dbg_data  in  8  debug byte.
dbg_ready  out  1  debug byte accepted when dbg_valid & dbg_ready.
tx_order  out  1  one-cycle send pulse to the transmitter.
tx_data  out  8  byte for the transmitter; valid while tx_order=1.
tx_sendable  in  1  transmitter idle and not being ordered this cycle.
fifo_count  out  ADDR_W+1  bytes currently queued.
busy  out  1  serializer active OR fifo_count≠0 OR drain FSM not in D_IDLE.

Behaviour:
- Reset (rstn=0 at posedge): FIFO emptied, serializer idle, drain FSM = D_IDLE, last_grant = DBG.
  - Registered outputs after reset: tx_order=0, tx_data=0, fifo_count=0, busy=0.
  - Contents are dropped mid-word or mid-drain. The transmitter shares rstn, so any in-flight frame aborts there too.
- Push side: at most one byte enters the FIFO per cycle. full = (fifo_count==DEPTH), using the registered count.
  - No push while full, even if a pop occurs in the same cycle.
- Arbitration:
  - Readies are combinational from registered state and the other port's valid. Valids must not depend on readies.
  - core_ready = ser_idle & ~full & (~dbg_valid | last_grant==DBG).
  - dbg_ready = ser_idle & ~full & (~core_valid | last_grant==CORE).
  - On each acceptance, last_grant is updated to the accepted port. Simultaneous requests therefore alternate, and the core wins first after reset.
  - A core word is never interleaved with debug bytes.
- Serializer:
  - On core accept, latch core_data and core_size into shift register and remaining count; ser_idle=0 from the next cycle.
  - Each cycle while active and not full: push shift[7:0], shift right by 8, decrement remaining. After the final byte, ser_idle=1 next cycle.
  - A full FIFO stalls the serializer without data loss.
- Debug accept: dbg_data is pushed in the same cycle.
- Drain FSM (states D_IDLE, D_ORDER, D_WAIT):
  - D_IDLE: if fifo_count≠0 and tx_sendable=1, then at the edge: register tx_data=head, tx_order=1, pop head, go to D_ORDER.
  - D_ORDER: tx_order=1 for exactly this cycle. The transmitter takes the byte; tx_sendable reads 0 here. Next state is D_WAIT, with tx_order=0.
  - D_WAIT: hold until tx_sendable=1, then go to D_IDLE. The next order is issued no earlier than the following cycle.
  - tx_order is never high on two consecutive cycles. tx_data holds its value until the next order.
- Latency:
  - Debug byte accepted in cycle t into an empty FIFO with the drain FSM idle: tx_order high in cycle t+2.
  - Core word accepted in cycle t: byte 0 tx_order high in cycle t+3.
- Counting: fifo_count changes by +1 (push), -1 (pop), or 0 (push and pop together, or neither). Pointers wrap modulo DEPTH.

Decomposition:
- Drain state encodings (D_IDLE=0, D_ORDER=1, D_WAIT=2) and grant encodings (CORE=0, DBG=1) go in the shared include, next to the baud and clock constants.
- The FIFO is one natural sub-module, uart_byte_fifo (DEPTH, ADDR_W; push/pop/full/empty/count/head). It is reusable on the receive side.

Test Plan:
1. Idle; debug byte 0x41 for one cycle at t -> tx_order pulse in cycle t+2 with tx_data=0x41. No further pulse; busy returns to 0 after tx_sendable goes back to 1.
2. Core word 0x44332211, size=3 -> core_ready low for 4 cycles after accept. Orders carry 0x11, 0x22, 0x33, 0x44 in that order.
3. core_valid (0xAA, size 0) and dbg_valid (0x55) held together for 4 accepts -> accept order core, dbg, core, dbg. Orders carry AA, 55, AA, 55.
4. Transmitter model holds tx_sendable=0; push 17 debug bytes with DEPTH=16 -> fifo_count reaches 16 and dbg_ready=0. The 17th byte is accepted only after the first pop once tx_sendable=1.
5. After an order, keep tx_sendable=0 for 500 cycles -> FSM stays in D_WAIT with no tx_order. Raise tx_sendable -> next order exactly 2 cycles later.
6. rstn low for one cycle during the third byte of a 4-byte word -> next cycle: tx_order=0, fifo_count=0, busy=0, core_ready=1. Remaining bytes are never sent.
